// File: rtl/top_wrapper_if.sv
// Serial link and spectrum output bundle for the 128-point DFT block.
// master drives the serial pins and observes the bins; slave is the DFT block.
interface top_wrapper_if;
    logic                ss;
    logic                clk_in;
    logic                data_in;
    logic [0:127][15:0]  outReal;
    logic [0:127][15:0]  outComplex;

    modport master (output ss, output clk_in, output data_in,
                    input outReal, input outComplex);
    modport slave  (input ss, input clk_in, input data_in,
                    output outReal, output outComplex);
endinterface

// File: rtl/top_wrapper.sv
// Serial-in 128-point DFT: SPI-style byte receiver, capture/working buffers and one MAC engine.
// Define TOP_WRAPPER_SIGNED_SAMPLES_EN to treat samples as two's-complement instead of unsigned.
module top_wrapper (
    input  logic        clk,
    input  logic        n_rst,
    top_wrapper_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MAC, WB} state_t;
    typedef logic [0:127][7:0] rom_t;

    function automatic logic signed [7:0] quarter(input int q);
        case (q)
            0: return 8'sd127;   1: return 8'sd127;   2: return 8'sd126;   3: return 8'sd126;
            4: return 8'sd125;   5: return 8'sd123;   6: return 8'sd122;   7: return 8'sd120;
            8: return 8'sd117;   9: return 8'sd115;  10: return 8'sd112;  11: return 8'sd109;
           12: return 8'sd106;  13: return 8'sd102;  14: return 8'sd98;   15: return 8'sd94;
           16: return 8'sd90;   17: return 8'sd85;   18: return 8'sd81;   19: return 8'sd76;
           20: return 8'sd71;   21: return 8'sd65;   22: return 8'sd60;   23: return 8'sd54;
           24: return 8'sd49;   25: return 8'sd43;   26: return 8'sd37;   27: return 8'sd31;
           28: return 8'sd25;   29: return 8'sd19;   30: return 8'sd12;   31: return 8'sd6;
           default: return 8'sd0;
        endcase
    endfunction

    // Full-period cosine unfolded from the first quadrant; rounding is odd-symmetric so folds are exact.
    function automatic rom_t build_rom();
        rom_t rom;
        int   v;
        for (int m = 0; m < 128; m++) begin
            if (m <= 32)      v = quarter(m);
            else if (m < 64)  v = -quarter(64 - m);
            else if (m <= 96) v = -quarter(m - 64);
            else              v = quarter(128 - m);
            rom[7'(m)] = 8'(v);
        end
        return rom;
    endfunction

    localparam rom_t COS_ROM = build_rom();

    function automatic logic signed [8:0] widen(input logic [7:0] x);
`ifdef TOP_WRAPPER_SIGNED_SAMPLES_EN
        return {x[7], x};
`else
        return {1'b0, x};
`endif
    endfunction

    function automatic logic signed [15:0] scale_bin(input logic signed [23:0] acc);
        return 16'(acc >>> 7);
    endfunction

    logic [1:0]          ss_sync, sck_sync, sdat_sync;
    logic                sck_prev;
    logic                ss_s, rise, bit_last, byte_wr, frame_done, launch;
    logic [2:0]          bit_cnt;
    logic [6:0]          idx;
    logic [7:0]          shreg, byte_val;
    logic [0:127][7:0]   cap, cap_nxt, work;
    state_t              state, state_nxt;
    logic                pending;
    logic [6:0]          k, n, m, m_sin;
    logic signed [23:0]  re_acc, im_acc;
    logic signed [8:0]   samp;
    logic signed [7:0]   cw, sw;
    logic signed [16:0]  prod_re, prod_im;
    logic [0:127][15:0]  bin_re, bin_im;

    assign ss_s       = ss_sync[1];
    assign rise       = sck_sync[1] & ~sck_prev & ~ss_s;
    assign bit_last   = (bit_cnt == 3'd7);
    assign byte_wr    = rise & bit_last;
    assign frame_done = byte_wr & (idx == 7'd127);
    assign byte_val   = {sdat_sync[1], shreg[6:0]};

    always_ff @(posedge clk) begin
        if (n_rst) begin
            ss_sync   <= 2'b11;
            sck_sync  <= 2'b00;
            sdat_sync <= 2'b00;
            sck_prev  <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[0], bus.ss};
            sck_sync  <= {sck_sync[0], bus.clk_in};
            sdat_sync <= {sdat_sync[0], bus.data_in};
            sck_prev  <= sck_sync[1];
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            bit_cnt <= '0;
            idx     <= '0;
            shreg   <= '0;
        end else if (ss_s) begin
            bit_cnt <= '0;
            idx     <= '0;
        end else if (rise) begin
            shreg[bit_cnt] <= sdat_sync[1];
            bit_cnt        <= bit_cnt + 3'd1;
            if (bit_last)
                idx <= idx + 7'd1;
        end
    end

    // The byte completing on this edge is forwarded so a launch copies the finished frame.
    always_comb begin
        cap_nxt = cap;
        if (byte_wr)
            cap_nxt[idx] = byte_val;
    end

    always_ff @(posedge clk) begin
        if (n_rst) cap <= '0;
        else       cap <= cap_nxt;
    end

    assign launch = ((state == IDLE) && frame_done) ||
                    ((state == WB) && (k == 7'd127) && (pending || frame_done));

    always_ff @(posedge clk) begin
        if (n_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (frame_done) state_nxt = MAC;
            MAC:  if (n == 7'd127) state_nxt = WB;
            WB: begin
                if (k != 7'd127 || launch) state_nxt = MAC;
                else                       state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign m_sin   = m + 7'd96;
    assign samp    = widen(work[n]);
    assign cw      = $signed(COS_ROM[m]);
    assign sw      = $signed(COS_ROM[m_sin]);
    assign prod_re = samp * cw;
    assign prod_im = samp * sw;

    // m tracks (k*n) mod 128 incrementally; k wraps to 0 after bin 127.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            pending <= 1'b0;
            k       <= '0;
            n       <= '0;
            m       <= '0;
            re_acc  <= '0;
            im_acc  <= '0;
            work    <= '0;
            bin_re  <= '0;
            bin_im  <= '0;
        end else begin
            if (state == MAC) begin
                re_acc <= re_acc + 24'(prod_re);
                im_acc <= im_acc - 24'(prod_im);
                n      <= n + 7'd1;
                m      <= m + k;
            end
            if (state == WB) begin
                bin_re[k] <= scale_bin(re_acc);
                bin_im[k] <= scale_bin(im_acc);
                re_acc    <= '0;
                im_acc    <= '0;
                n         <= '0;
                m         <= '0;
                k         <= k + 7'd1;
            end
            if (launch) begin
                work    <= cap_nxt;
                pending <= 1'b0;
                k       <= '0;
                n       <= '0;
                m       <= '0;
                re_acc  <= '0;
                im_acc  <= '0;
            end else if (frame_done && state != IDLE) begin
                pending <= 1'b1;
            end
        end
    end

    assign bus.outReal    = bin_re;
    assign bus.outComplex = bin_im;
endmodule

// File: tb/tb_top_wrapper.sv
// Bench for top_wrapper: directed serial frames against a floating-point DFT model of the bins.
module tb_top_wrapper;
    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    top_wrapper_if bus();
    top_wrapper dut (.clk(clk), .n_rst(n_rst), .bus(bus));

`ifdef TOP_WRAPPER_SIGNED_SAMPLES_EN
    localparam int DC_255 = -127;
    localparam int IMP    = -1;
`else
    localparam int DC_255 = 32385;
    localparam int IMP    = 253;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   tw_c [128];
    int   tw_s [128];
    int   exp_re [128];
    int   exp_im [128];
    logic check_en = 1'b0;

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    function automatic int sval(input logic [7:0] b);
`ifdef TOP_WRAPPER_SIGNED_SAMPLES_EN
        return int'($signed(b));
`else
        return int'(b);
`endif
    endfunction

    task automatic build_tw();
        real pi;
        pi = 3.14159265358979323846;
        for (int i = 0; i < 128; i++) begin
            tw_c[i] = rnd(127.0 * $cos(2.0 * pi * i / 128.0));
            tw_s[i] = rnd(127.0 * $sin(2.0 * pi * i / 128.0));
        end
    endtask

    task automatic zero_model();
        for (int i = 0; i < 128; i++) begin
            exp_re[i] = 0;
            exp_im[i] = 0;
        end
    endtask

    // Frame: byte `pos` holds `sp`, every other byte holds `rest`.
    task automatic set_model(input int pos, input int sp, input int rest);
        int re, im, x;
        for (int kk = 0; kk < 128; kk++) begin
            re = 0;
            im = 0;
            for (int nn = 0; nn < 128; nn++) begin
                x  = sval(8'((nn == pos) ? sp : rest));
                re = re + x * tw_c[(kk * nn) % 128];
                im = im - x * tw_s[(kk * nn) % 128];
            end
            exp_re[kk] = re >>> 7;
            exp_im[kk] = im >>> 7;
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (check_en) begin
            for (int kk = 0; kk < 128; kk++) begin
                n_checks++;
                if (int'($signed(bus.outReal[kk])) != exp_re[kk]) begin
                    n_fail++;
                    $display("FAIL outReal[%0d] at %0t: got %0d, expected %0d",
                             kk, $time, $signed(bus.outReal[kk]), exp_re[kk]);
                end
                n_checks++;
                if (int'($signed(bus.outComplex[kk])) != exp_im[kk]) begin
                    n_fail++;
                    $display("FAIL outComplex[%0d] at %0t: got %0d, expected %0d",
                             kk, $time, $signed(bus.outComplex[kk]), exp_im[kk]);
                end
            end
        end
    end

    task automatic check_lit(input string name, input logic [15:0] act, input int expv);
        n_checks++;
        if (int'($signed(act)) != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), expv);
        end
    endtask

    task automatic window(input int cycles);
        check_en = 1'b1;
        repeat (cycles) @(negedge clk);
        check_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            bus.data_in = b[i];
            bus.clk_in  = 1'b0;
            repeat (3) @(negedge clk);
            bus.clk_in  = 1'b1;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic send_frame(input int pos, input int sp, input int rest, input int count);
        for (int i = 0; i < count; i++)
            send_byte(8'((i == pos) ? sp : rest));
        bus.clk_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.ss      = 1'b0;
        bus.clk_in  = 1'b0;
        bus.data_in = 1'b0;
        n_rst       = 1'b1;
        build_tw();
        zero_model();

        @(negedge clk);
        check_en = 1'b1;
        repeat (4) @(negedge clk);
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        check_en = 1'b0;
        check_lit("reset_real0", bus.outReal[0], 0);

        // All-255 frame, then an impulse frame straight after while the first is computing.
        set_model(0, 255, 255);
        send_frame(0, 255, 255, 128);
        fork
            send_frame(0, 255, 0, 128);
            begin
                repeat (16567) @(negedge clk);
                window(3);
                check_lit("dc255_real0", bus.outReal[0], DC_255);
                check_lit("dc255_real64", bus.outReal[64], 0);
                check_lit("dc255_imag0", bus.outComplex[0], 0);
            end
        join
        set_model(0, 255, 0);
        repeat (16600) @(negedge clk);
        window(3);
        check_lit("impulse_real0", bus.outReal[0], IMP);
        check_lit("impulse_real77", bus.outReal[77], IMP);
        check_lit("impulse_imag5", bus.outComplex[5], 0);

        // Partial frame aborted by ss, then a full byte1=64 frame.
        send_frame(0, 255, 255, 37);
        bus.ss = 1'b1;
        repeat (8) @(negedge clk);
        bus.ss = 1'b0;
        repeat (8) @(negedge clk);
        set_model(1, 64, 0);
        send_frame(1, 64, 0, 128);
        repeat (16600) @(negedge clk);
        window(3);
        check_lit("byte1_real32", bus.outReal[32], 0);
        check_lit("byte1_imag32", bus.outComplex[32], -64);
        check_lit("byte1_real0", bus.outReal[0], 63);

        // One-cycle reset in the middle of a computation.
        send_frame(0, 255, 255, 128);
        repeat (8000) @(negedge clk);
        zero_model();
        n_rst    = 1'b1;
        check_en = 1'b1;
        @(negedge clk);
        n_rst = 1'b0;
        repeat (1999) @(negedge clk);
        check_en = 1'b0;
        check_lit("after_reset_real0", bus.outReal[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/top_wrapper.md
# top_wrapper

Serial-in, 128-point DFT block. It receives a frame of 128 8-bit samples over an SPI-style link (`ss`, `clk_in`, `data_in`) and computes the full 128-bin complex spectrum with a single sequential multiply-accumulate engine. It presents all bins in parallel on `outReal` and `outComplex`. It sits at the top of the FFT datapath, between the external serial master and downstream spectrum consumers.

## Interface
Parameters: none (frame size 128, sample width 8, bin width 16, all fixed).

- `clk` in 1: system clock; all logic is on its rising edge.
- `n_rst` in 1: synchronous, active-high reset, despite the name.
- `ss` in 1: slave select, active low; asynchronous to `clk`.
- `clk_in` in 1: serial clock; data is sampled on its rising edge; asynchronous to `clk`.
- `data_in` in 1: serial data, LSB of each byte first.
- `outReal` out [0:127][15:0]: signed real part of bins 0..127.
- `outComplex` out [0:127][15:0]: signed imaginary part of bins 0..127.

## Operation
- **Synchronizers:** `ss`, `clk_in` and `data_in` each pass through a 2-flop synchronizer. A `clk_in` rise is detected when the synchronized value goes 0→1, and it is acted on only while synchronized `ss`=0.
- **Receiver:**
  - 3-bit bit counter; bit i of the current byte is taken on the i-th rise.
  - After 8 bits the byte is written to capture buffer entry `idx` (7-bit), then `idx` increments.
  - When entry 127 is written, a frame-complete pulse fires and `idx` wraps to 0.
- **Abort:** synchronized `ss`=1 clears the bit counter and `idx`. The partial frame is discarded; entries already in the capture buffer remain.
- **Launch:** on frame complete:
  - If the engine is IDLE, the capture buffer is copied into the working buffer and computation starts.
  - If the engine is busy, a one-deep pending flag is set. On completion, the pending flag causes a copy from the capture buffer and a restart.
  - Additional frames arriving while pending is already set are merged into that single pending request.
- **Engine FSM:**
  - IDLE → MAC on start.
  - MAC loops n=0..127 for the current bin k.
  - MAC → WB (write bin k).
  - WB → MAC with k+1, or → IDLE (or → MAC with k=0 if pending) after k=127.
- **Twiddle ROM:**
  - 128 entries of round-half-away-from-zero(127·cos(2πm/128)), signed 8-bit, built by a constant function.
  - cos index is m=(k·n) mod 128; sin index is (m+96) mod 128.
- **Arithmetic:**
  - Samples are unsigned 8-bit by default.
  - re_acc += x[n]·cos and im_acc −= x[n]·sin, in 24-bit signed accumulators.
  - Written bin value = acc >>> 7, truncated to 16 bits; no saturation is needed.
- **Outputs:** each bin register holds its value until overwritten by the next computation. Bins not yet recomputed keep the previous frame's values.

## Timing
- Reset: all `outReal`/`outComplex` entries 0, FSM IDLE, counters 0, pending 0, buffers 0.
- Reset mid-frame or mid-compute abandons everything and returns to the reset state on the next edge.
- The receiver requires each `clk_in` high and low phase to last ≥3 `clk` cycles. `data_in` must be stable from 3 cycles before until 3 cycles after a `clk_in` rise.
- A `clk_in` rise is acted on 3 `clk` cycles after the pin edge; frame complete occurs on that same cycle.
- Computation start S is the cycle after frame complete.
- Each bin takes 128 MAC cycles plus 1 WB cycle. Bin k updates at the end of cycle S+129k+128, and the full spectrum is valid at S+16511.
- A `ss` deassertion during compute does not affect the engine.

## Configuration
- `TOP_WRAPPER_SIGNED_SAMPLES_EN` defined: samples are two's-complement signed 8-bit (255 = −1).
- Undefined (default): samples are unsigned 0..255.
- The datapath width is unchanged in both cases.

## Test plan
- Reset, then all 128 bytes = 255 (ss low, LSB first) → after 16512 cycles, outReal[0]=32385, every other outReal and all outComplex = 0. With the macro defined: outReal[0]=−127, others 0.
- Impulse frame (byte0=255, rest 0) → all 128 outReal=253 and all outComplex=0. With the macro defined: all outReal=−1.
- Byte1=64, rest 0 → outReal[32]=0 and outComplex[32]=−64.
- Two frames back-to-back without raising ss (255s, then impulse) → pending set; after both computations, the impulse spectrum is present.
- ss raised after 37 bytes, then lowered and a full 255 frame sent → DC result 32385 (the partial frame is ignored).
- Assert `n_rst` for 1 cycle midway through computation → all outputs 0 next cycle; no further updates without a new frame.
